// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the sequential ALU: opcode encodings and FSM states.
// No ports; imported by seq_alu_if and seq_alu.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD    = 6'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 6'd1;
    localparam logic [OP_W-1:0] OP_SHL    = 6'd2;
    localparam logic [OP_W-1:0] OP_SHR    = 6'd3;
    localparam logic [OP_W-1:0] OP_PASS   = 6'd4;
    localparam logic [OP_W-1:0] OP_LOADLO = 6'd5;
    localparam logic [OP_W-1:0] OP_LOADHI = 6'd6;
    localparam logic [OP_W-1:0] OP_PASS2  = 6'd7;
    localparam logic [OP_W-1:0] OP_EQ     = 6'd8;
    localparam logic [OP_W-1:0] OP_LTU    = 6'd9;
    localparam logic [OP_W-1:0] OP_GTU    = 6'd10;
    localparam logic [OP_W-1:0] OP_NOTF   = 6'd11;

    // Controller states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if
// Request/response bundle of the sequential ALU.
//   Request : in_valid, in_ready, op, a, b, imm
//   Response: out_valid, out_ready, result, flag
//   Status  : busy
// slave  modport: the ALU side.  master modport: the requester side.
// ---------------------------------------------------------------------------
interface seq_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [OP_W-1:0]      op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH/2-1:0]   imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic                 flag;
    logic                 busy;

    modport slave (
        input  in_valid, op, a, b, imm, out_ready,
        output in_ready, out_valid, result, flag, busy
    );

    modport master (
        output in_valid, op, a, b, imm, out_ready,
        input  in_ready, out_valid, result, flag, busy
    );
endinterface

// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
// Iterative shifter: moves one bit per clock, filling vacated bits with 1.
//   clock, reset : clock and asynchronous active-high reset
//   i_load       : capture i_data / i_count / i_dir
//   i_dir        : 0 = shift left, 1 = shift right
//   i_data       : value to shift
//   i_count      : number of single-bit steps to perform
//   o_next       : the value the register will hold after the next step
//   o_done       : the coming edge performs the final step
// ---------------------------------------------------------------------------
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNTW-1:0]  i_count,
    output logic [WIDTH-1:0] o_next,
    output logic             o_done
);
    logic [WIDTH-1:0] r_data;
    logic [CNTW-1:0]  r_count;
    logic             r_dir;
    logic [WIDTH-1:0] w_next;

    // Direction is latched because the opcode input is free to change while shifting
    assign w_next = r_dir ? {1'b1, r_data[WIDTH-1:1]} : {r_data[WIDTH-2:0], 1'b1};
    assign o_next = w_next;
    assign o_done = (r_count == CNTW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_count <= i_count;
            r_dir   <= i_dir;
        end else if (r_count != '0) begin
            r_data  <= w_next;
            r_count <= r_count - CNTW'(1);
        end
    end
endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Sequential ALU with valid/ready handshakes. Most ops complete in one cycle;
// SHL/SHR iterate one bit per cycle through shift_unit.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : seq_alu_if.slave (request, response and busy status)
// ---------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic      clock,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    logic [0:0]       r_state;
    logic             r_outValid;
    logic [WIDTH-1:0] r_result;
    logic             r_flag;

    logic             w_accept;
    logic             w_isShift;
    logic             w_shiftLoad;
    logic             w_shiftLast;
    logic [CNTW-1:0]  w_shiftAmt;
    logic [WIDTH-1:0] w_shiftNext;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_aluFlag;

    // A new request is only taken when the current result slot will be free
    assign bus.in_ready  = (r_state == ST_IDLE) && (!r_outValid || bus.out_ready);
    assign bus.out_valid = r_outValid;
    assign bus.result    = r_result;
    assign bus.flag      = r_flag;
    assign bus.busy      = (r_state == ST_SHIFT);

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_isShift   = (bus.op == OP_SHL) || (bus.op == OP_SHR);
    // Shift distances beyond WIDTH saturate; WIDTH steps already give all ones
    assign w_shiftAmt  = (bus.b >= WIDTH'(WIDTH)) ? CNTW'(WIDTH) : bus.b[CNTW-1:0];
    assign w_shiftLoad = w_accept && w_isShift && (w_shiftAmt != '0);

    shift_unit #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_shift (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_shiftLoad),
        .i_dir   (bus.op == OP_SHR),
        .i_data  (bus.a),
        .i_count (w_shiftAmt),
        .o_next  (w_shiftNext),
        .o_done  (w_shiftLast)
    );

    // Single-cycle result and flag; a zero-distance shift simply returns a
    always_comb begin
        w_aluResult = '0;
        w_aluFlag   = r_flag;
        case (bus.op)
            OP_ADD:            w_aluResult = bus.a + bus.b;
            OP_SUB:            w_aluResult = bus.a - bus.b;
            OP_SHL, OP_SHR:    w_aluResult = bus.a;
            OP_PASS, OP_PASS2: w_aluResult = bus.a;
            OP_LOADLO:         w_aluResult = {bus.a[WIDTH-1:WIDTH/2], bus.imm};
            OP_LOADHI:         w_aluResult = {bus.imm, bus.a[WIDTH/2-1:0]};
            OP_EQ: begin
                w_aluFlag   = (bus.a == bus.b);
                w_aluResult = {{(WIDTH-1){1'b0}}, w_aluFlag};
            end
            OP_LTU: begin
                w_aluFlag   = (bus.a < bus.b);
                w_aluResult = {{(WIDTH-1){1'b0}}, w_aluFlag};
            end
            OP_GTU: begin
                w_aluFlag   = (bus.a > bus.b);
                w_aluResult = {{(WIDTH-1){1'b0}}, w_aluFlag};
            end
            OP_NOTF: begin
                w_aluFlag   = ~r_flag;
                w_aluResult = {{(WIDTH-1){1'b0}}, w_aluFlag};
            end
            default: w_aluResult = '0;
        endcase
    end

    // A result produced on the same edge as the old one is consumed keeps out_valid high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_flag     <= 1'b0;
        end else begin
            if (r_outValid && bus.out_ready) begin
                r_outValid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_shiftLoad) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_result   <= w_aluResult;
                            r_outValid <= 1'b1;
                            r_flag     <= w_aluFlag;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_shiftLast) begin
                        r_result   <= w_shiftNext;
                        r_outValid <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu: a table of directed vectors with
// hand-computed results, plus hand-written sequences for busy timing,
// backpressure and reset during a shift.
// ---------------------------------------------------------------------------
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W/2-1:0] imm;
        logic [W-1:0] expResult;
        logic         expFlag;
        int           expLatency;
    } vector_t;

    logic clock;
    logic reset;
    int   checkCount;
    int   passCount;
    vector_t vecs[23];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic setVec(input int i, input logic [5:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W/2-1:0] imm,
                          input logic [W-1:0] res, input logic flg, input int lat);
        vecs[i].op         = op;
        vecs[i].a          = a;
        vecs[i].b          = b;
        vecs[i].imm        = imm;
        vecs[i].expResult  = res;
        vecs[i].expFlag    = flg;
        vecs[i].expLatency = lat;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Waits for in_ready, presents one request for a single accepting edge
    task automatic applyStimulus(input logic [5:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W/2-1:0] imm);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            stepCycle();
            guard++;
        end
        checkOutput("in_ready before issue", {31'b0, bus.in_ready}, 1);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.imm      = imm;
        bus.in_valid = 1'b1;
        stepCycle();
        bus.in_valid = 1'b0;
    endtask

    // Called right after the accepting edge; counts cycles until out_valid
    task automatic waitResult(output int cycles);
        cycles = 1;
        while (!bus.out_valid && cycles < 100) begin
            stepCycle();
            cycles++;
        end
    endtask

    initial begin
        int lat;
        int busyCycles;
        int readyDuringBusy;
        int lateValid;

        clock = 1'b0;
        reset = 1'b1;
        checkCount = 0;
        passCount  = 0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.imm       = '0;
        bus.out_ready = 1'b1;

        setVec(0,  OP_ADD,    32'hFFFF_FFFF, 32'd1,         16'h0,    32'h0000_0000, 1'b0, 1);
        setVec(1,  OP_SUB,    32'd3,         32'd5,         16'h0,    32'hFFFF_FFFE, 1'b0, 1);
        setVec(2,  OP_SHL,    32'h0000_00F0, 32'd4,         16'h0,    32'h0000_0F0F, 1'b0, 5);
        setVec(3,  OP_SHR,    32'h0000_0000, 32'd40,        16'h0,    32'hFFFF_FFFF, 1'b0, 33);
        setVec(4,  OP_SHL,    32'h1234_5678, 32'd0,         16'h0,    32'h1234_5678, 1'b0, 1);
        setVec(5,  OP_SHR,    32'h8000_0000, 32'd1,         16'h0,    32'hC000_0000, 1'b0, 2);
        setVec(6,  OP_PASS,   32'hDEAD_BEEF, 32'd9,         16'h0,    32'hDEAD_BEEF, 1'b0, 1);
        setVec(7,  OP_PASS2,  32'hCAFE_F00D, 32'd9,         16'h0,    32'hCAFE_F00D, 1'b0, 1);
        setVec(8,  OP_LOADLO, 32'hAAAA_5555, 32'd0,         16'h1234, 32'hAAAA_1234, 1'b0, 1);
        setVec(9,  OP_LOADHI, 32'hAAAA_5555, 32'd0,         16'h1234, 32'h1234_5555, 1'b0, 1);
        setVec(10, OP_LTU,    32'd1,         32'd2,         16'h0,    32'd1,         1'b1, 1);
        setVec(11, OP_NOTF,   32'd0,         32'd0,         16'h0,    32'd0,         1'b0, 1);
        setVec(12, OP_EQ,     32'd7,         32'd7,         16'h0,    32'd1,         1'b1, 1);
        setVec(13, 6'd12,     32'hFFFF_0000, 32'd3,         16'h0,    32'd0,         1'b1, 1);
        setVec(14, OP_GTU,    32'd2,         32'd1,         16'h0,    32'd1,         1'b1, 1);
        setVec(15, OP_GTU,    32'd1,         32'd2,         16'h0,    32'd0,         1'b0, 1);
        setVec(16, 6'd63,     32'h5555_5555, 32'd1,         16'h0,    32'd0,         1'b0, 1);
        setVec(17, OP_NOTF,   32'd0,         32'd0,         16'h0,    32'd1,         1'b1, 1);
        setVec(18, OP_EQ,     32'd5,         32'd6,         16'h0,    32'd0,         1'b0, 1);
        setVec(19, OP_ADD,    32'h7FFF_FFFF, 32'd1,         16'h0,    32'h8000_0000, 1'b0, 1);
        setVec(20, OP_SHR,    32'h0F0F_0000, 32'd8,         16'h0,    32'hFF0F_0F00, 1'b0, 9);
        setVec(21, OP_SHL,    32'h0000_0000, 32'd31,        16'h0,    32'h7FFF_FFFF, 1'b0, 32);
        setVec(22, OP_SHR,    32'h0000_0012, 32'hFFFF_FFFF, 16'h0,    32'hFFFF_FFFF, 1'b0, 33);

        // Reset state
        #12;
        checkOutput("reset out_valid", {31'b0, bus.out_valid}, 0);
        checkOutput("reset result",    bus.result, 0);
        checkOutput("reset flag",      {31'b0, bus.flag}, 0);
        checkOutput("reset busy",      {31'b0, bus.busy}, 0);
        checkOutput("reset in_ready",  {31'b0, bus.in_ready}, 1);
        stepCycle();
        reset = 1'b0;

        // First request is taken on the first edge after reset release
        applyStimulus(OP_ADD, 32'd1, 32'd1, 16'h0);
        waitResult(lat);
        checkOutput("first op latency", lat, 1);
        checkOutput("first op result",  bus.result, 2);

        // Table of vectors, out_ready held high
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm);
            waitResult(lat);
            checkOutput($sformatf("vec%0d out_valid", i), {31'b0, bus.out_valid}, 1);
            checkOutput($sformatf("vec%0d result", i),    bus.result, vecs[i].expResult);
            checkOutput($sformatf("vec%0d flag", i),      {31'b0, bus.flag}, {31'b0, vecs[i].expFlag});
            checkOutput($sformatf("vec%0d latency", i),   lat, vecs[i].expLatency);
        end

        // Busy window of a 4-step shift
        applyStimulus(OP_SHL, 32'h0000_00F0, 32'd4, 16'h0);
        busyCycles = 0;
        readyDuringBusy = 0;
        for (int c = 0; c < 100 && !bus.out_valid; c++) begin
            if (bus.busy) busyCycles++;
            if (bus.busy && bus.in_ready) readyDuringBusy++;
            stepCycle();
        end
        checkOutput("shl busy cycles",       busyCycles, 4);
        checkOutput("shl in_ready while busy", readyDuringBusy, 0);
        checkOutput("shl result",            bus.result, 32'h0000_0F0F);
        checkOutput("shl busy after done",   {31'b0, bus.busy}, 0);

        // Backpressure: result held, in_ready low, then same-edge replace
        stepCycle();
        bus.out_ready = 1'b0;
        applyStimulus(OP_ADD, 32'd2, 32'd3, 16'h0);
        checkOutput("bp out_valid", {31'b0, bus.out_valid}, 1);
        checkOutput("bp result",    bus.result, 5);
        bus.op       = OP_ADD;
        bus.a        = 32'd10;
        bus.b        = 32'd10;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput($sformatf("bp hold%0d result", c),    bus.result, 5);
            checkOutput($sformatf("bp hold%0d out_valid", c), {31'b0, bus.out_valid}, 1);
            checkOutput($sformatf("bp hold%0d in_ready", c),  {31'b0, bus.in_ready}, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp release in_ready", {31'b0, bus.in_ready}, 1);
        stepCycle();
        bus.in_valid = 1'b0;
        checkOutput("bp replace out_valid", {31'b0, bus.out_valid}, 1);
        checkOutput("bp replace result",    bus.result, 20);
        stepCycle();
        checkOutput("bp drained out_valid", {31'b0, bus.out_valid}, 0);
        checkOutput("bp drained in_ready",  {31'b0, bus.in_ready}, 1);

        // Reset in the middle of a shift
        applyStimulus(OP_LTU, 32'd1, 32'd2, 16'h0);
        waitResult(lat);
        checkOutput("pre-reset flag", {31'b0, bus.flag}, 1);
        applyStimulus(OP_SHL, 32'h0000_00F0, 32'd10, 16'h0);
        stepCycle();
        stepCycle();
        checkOutput("mid-shift busy", {31'b0, bus.busy}, 1);
        reset = 1'b1;
        #1;
        checkOutput("async reset out_valid", {31'b0, bus.out_valid}, 0);
        checkOutput("async reset flag",      {31'b0, bus.flag}, 0);
        checkOutput("async reset busy",      {31'b0, bus.busy}, 0);
        checkOutput("async reset result",    bus.result, 0);
        stepCycle();
        reset = 1'b0;
        lateValid = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) lateValid++;
            stepCycle();
        end
        checkOutput("no late shift result", lateValid, 0);
        checkOutput("post-reset in_ready",  {31'b0, bus.in_ready}, 1);
        applyStimulus(OP_SUB, 32'd10, 32'd4, 16'h0);
        waitResult(lat);
        checkOutput("post-reset op latency", lat, 1);
        checkOutput("post-reset op result",  bus.result, 6);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
